// File: rtl/mod_reduce.sv
// mod_reduce: conditional single subtraction of M from a doubled operand.
// Returns (a >= M) ? a - M : a as an N-bit value. The subtraction runs
// CHUNK bits per cycle with a registered borrow between slices, so there is
// never a full-width carry chain. The request is latched on start; done
// pulses once when result is updated.
module mod_reduce #(
  parameter int unsigned N     = 1024,
  parameter int unsigned CHUNK = 128
) (
  input  logic           clk,
  input  logic           restn,
  input  logic           start,
  input  logic [N:0]     in_value,
  input  logic [N-1:0]   modulus,
  output logic [N-1:0]   result,
  output logic           done,
  output logic           busy
);

  localparam int unsigned NCH = N / CHUNK;
  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    FINISH
  } state_t;

  state_t           state;
  logic [N:0]       a_q;
  logic [N-1:0]     m_q;
  logic [N-1:0]     diff_q;
  logic [CW-1:0]    cnt;
  logic             borrow;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] m_sl;
  logic [CHUNK:0]   sub_w;
  logic             ge;

  // Select the current chunk of the latched operands and subtract with borrow-in.
  always_comb begin
    a_sl = '0;
    m_sl = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (cnt == CW'(i)) begin
        a_sl = a_q[i*CHUNK +: CHUNK];
        m_sl = m_q[i*CHUNK +: CHUNK];
      end
    end
    sub_w = {1'b0, a_sl} - {1'b0, m_sl} - {{CHUNK{1'b0}}, borrow};
  end

  // a >= M when the top bit is set or the full chained subtraction did not borrow.
  always_comb begin
    ge = a_q[N] | ~borrow;
  end

  // Busy whenever a request is in flight.
  always_comb begin
    busy = (state != IDLE);
  end

  // Control FSM, operand latches, chunked difference and registered outputs.
  always_ff @(posedge clk or negedge restn) begin
    if (!restn) begin
      state  <= IDLE;
      a_q    <= '0;
      m_q    <= '0;
      diff_q <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q    <= in_value;
            m_q    <= modulus;
            borrow <= 1'b0;
            cnt    <= '0;
            state  <= SUB;
          end
        end
        SUB: begin
          done <= 1'b0;
          for (int unsigned i = 0; i < NCH; i++) begin
            if (cnt == CW'(i)) begin
              diff_q[i*CHUNK +: CHUNK] <= sub_w[CHUNK-1:0];
            end
          end
          borrow <= sub_w[CHUNK];
          if (cnt == CW'(NCH - 1)) begin
            cnt   <= '0;
            state <= FINISH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FINISH: begin
          result <= ge ? diff_q : a_q[N-1:0];
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
